// File: rtl/io_port_pkg.sv
// ============================================================================
// Module : io_port_pkg
// Brief  : Shared width constant and depth helpers for the IO port FIFOs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package io_port_pkg;

  // Width of the CPU bus and of both external port words.
  localparam int IO_DATA_W = 32;

  // Pointer width for a FIFO of the given depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count width: one extra bit so the count can hold DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Legal depths are powers of two, at least 2, so pointers wrap for free.
  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO with combinational head and a drop pulse that
//          fires when a push is refused because the FIFO is full.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo
  import io_port_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              drop_o
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign dout_o  = mem_q[rd_ptr_q];

  // A pop on a full FIFO frees a slot in the same edge, so the push is kept.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    drop_o   = push_i && full_o && !do_pop;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents need no reset since the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/io_port_fifo.sv
// ============================================================================
// Module : io_port_fifo
// Brief  : Input and output port FIFOs beside the CPU bus mux, with sticky
//          overrun flags and zero-gated head outputs.
//          Optional macro STROBE_EDGE_EN: push the input FIFO only on the
//          rising edge of strobe instead of every cycle strobe is high.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module io_port_fifo
  import io_port_pkg::*;
#(
  parameter int DATA_W    = IO_DATA_W,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic              strobe,
  input  logic [DATA_W-1:0] input_data,
  input  logic              InPortout,
  output logic [DATA_W-1:0] BusMuxInInPortout,
  input  logic              OutPortin,
  input  logic [DATA_W-1:0] BusOut,
  output logic [DATA_W-1:0] output_data,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              in_empty,
  output logic              in_full,
  output logic              out_empty,
  output logic              out_full,
  output logic              in_overrun,
  output logic              out_overrun,
  input  logic              ovr_clr
);

  if (!depth_ok(IN_DEPTH)) begin : g_bad_in_depth
    $error("io_port_fifo: IN_DEPTH must be a power of two >= 2");
  end
  if (!depth_ok(OUT_DEPTH)) begin : g_bad_out_depth
    $error("io_port_fifo: OUT_DEPTH must be a power of two >= 2");
  end

  logic              in_push;
  logic              in_drop, out_drop;
  logic [DATA_W-1:0] in_head, out_head;
  logic              in_ovr_q, in_ovr_d;
  logic              out_ovr_q, out_ovr_d;

`ifdef STROBE_EDGE_EN
  logic strobe_prev_q;

  // Previous strobe level for rising-edge detection.
  always_ff @(posedge Clock) begin
    if (clear) begin
      strobe_prev_q <= 1'b0;
    end else begin
      strobe_prev_q <= strobe;
    end
  end

  assign in_push = strobe && !strobe_prev_q;
`else
  assign in_push = strobe;
`endif

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (IN_DEPTH)
  ) u_in_fifo (
    .clk_i   (Clock),
    .rst_i   (clear),
    .push_i  (in_push),
    .pop_i   (InPortout),
    .din_i   (input_data),
    .dout_o  (in_head),
    .empty_o (in_empty),
    .full_o  (in_full),
    .drop_o  (in_drop)
  );

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (OUT_DEPTH)
  ) u_out_fifo (
    .clk_i   (Clock),
    .rst_i   (clear),
    .push_i  (OutPortin),
    .pop_i   (out_ack),
    .din_i   (BusOut),
    .dout_o  (out_head),
    .empty_o (out_empty),
    .full_o  (out_full),
    .drop_o  (out_drop)
  );

  // Sticky overrun flags: a new drop beats a simultaneous clear request.
  always_comb begin
    in_ovr_d  = in_drop  ? 1'b1 : (ovr_clr ? 1'b0 : in_ovr_q);
    out_ovr_d = out_drop ? 1'b1 : (ovr_clr ? 1'b0 : out_ovr_q);
  end

  // Overrun flag registers.
  always_ff @(posedge Clock) begin
    if (clear) begin
      in_ovr_q  <= 1'b0;
      out_ovr_q <= 1'b0;
    end else begin
      in_ovr_q  <= in_ovr_d;
      out_ovr_q <= out_ovr_d;
    end
  end

  assign in_overrun        = in_ovr_q;
  assign out_overrun       = out_ovr_q;
  assign BusMuxInInPortout = in_empty  ? '0 : in_head;
  assign output_data       = out_empty ? '0 : out_head;
  assign out_valid         = !out_empty;

endmodule

`default_nettype wire

// File: tb/tb_io_port_fifo.sv
// ============================================================================
// Module : tb_io_port_fifo
// Brief  : Self-checking bench for io_port_fifo against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_io_port_fifo;

  localparam int DW   = 32;
  localparam int IN_D = 4;
  localparam int OUT_D = 4;

  logic          Clock = 1'b0;
  logic          clear = 1'b1;
  logic          strobe = 1'b0;
  logic [DW-1:0] input_data = '0;
  logic          InPortout = 1'b0;
  logic [DW-1:0] BusMuxInInPortout;
  logic          OutPortin = 1'b0;
  logic [DW-1:0] BusOut = '0;
  logic [DW-1:0] output_data;
  logic          out_valid;
  logic          out_ack = 1'b0;
  logic          in_empty, in_full, out_empty, out_full;
  logic          in_overrun, out_overrun;
  logic          ovr_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];
  bit m_in_ovr, m_out_ovr, m_prev_stb;

  io_port_fifo #(.DATA_W(DW), .IN_DEPTH(IN_D), .OUT_DEPTH(OUT_D)) dut (
    .Clock(Clock), .clear(clear), .strobe(strobe), .input_data(input_data),
    .InPortout(InPortout), .BusMuxInInPortout(BusMuxInInPortout),
    .OutPortin(OutPortin), .BusOut(BusOut), .output_data(output_data),
    .out_valid(out_valid), .out_ack(out_ack), .in_empty(in_empty),
    .in_full(in_full), .out_empty(out_empty), .out_full(out_full),
    .in_overrun(in_overrun), .out_overrun(out_overrun), .ovr_clr(ovr_clr)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of the model, applied with the inputs that were sampled at the edge.
  task automatic model_edge();
    bit push_req, in_set, out_set;
    if (clear) begin
      in_q.delete(); out_q.delete();
      m_in_ovr = 0; m_out_ovr = 0; m_prev_stb = 0;
      return;
    end
`ifdef STROBE_EDGE_EN
    push_req = strobe && !m_prev_stb;
`else
    push_req = strobe;
`endif
    m_prev_stb = strobe;
    in_set = 0; out_set = 0;
    if (InPortout && in_q.size() > 0) void'(in_q.pop_front());
    if (push_req) begin
      if (in_q.size() < IN_D) in_q.push_back(input_data); else in_set = 1;
    end
    if (out_ack && out_q.size() > 0) void'(out_q.pop_front());
    if (OutPortin) begin
      if (out_q.size() < OUT_D) out_q.push_back(BusOut); else out_set = 1;
    end
    m_in_ovr  = in_set  ? 1'b1 : (ovr_clr ? 1'b0 : m_in_ovr);
    m_out_ovr = out_set ? 1'b1 : (ovr_clr ? 1'b0 : m_out_ovr);
  endtask

  task automatic compare_all();
    check("bus",      BusMuxInInPortout, in_q.size()  > 0 ? in_q[0]  : '0);
    check("out_data", output_data,       out_q.size() > 0 ? out_q[0] : '0);
    check("out_valid", DW'(out_valid),   DW'(out_q.size() > 0));
    check("in_empty",  DW'(in_empty),    DW'(in_q.size() == 0));
    check("in_full",   DW'(in_full),     DW'(in_q.size() == IN_D));
    check("out_empty", DW'(out_empty),   DW'(out_q.size() == 0));
    check("out_full",  DW'(out_full),    DW'(out_q.size() == OUT_D));
    check("in_ovr",    DW'(in_overrun),  DW'(m_in_ovr));
    check("out_ovr",   DW'(out_overrun), DW'(m_out_ovr));
  endtask

  task automatic step(input logic clr, input logic stb, input logic [DW-1:0] din,
                      input logic ip, input logic op, input logic [DW-1:0] bo,
                      input logic ack, input logic oc);
    clear = clr; strobe = stb; input_data = din; InPortout = ip;
    OutPortin = op; BusOut = bo; out_ack = ack; ovr_clr = oc;
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    @(negedge Clock);
    // 1. reset
    step(1, 0, '0, 0, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0, '0, 0, 0);
    idle();
    check("rst_in_empty", DW'(in_empty), 1);
    check("rst_out_empty", DW'(out_empty), 1);
    check("rst_in_full", DW'(in_full), 0);
    check("rst_ovr", DW'({in_overrun, out_overrun}), 0);
    check("rst_bus", BusMuxInInPortout, 0);
    check("rst_out_data", output_data, 0);

    // 2. two strobed words, popped in order
    step(0, 1, 32'h11, 0, 0, '0, 0, 0); idle();
    step(0, 1, 32'h22, 0, 0, '0, 0, 0); idle();
    check("t2_head0", BusMuxInInPortout, 32'h11);
    step(0, 0, '0, 1, 0, '0, 0, 0);
    check("t2_head1", BusMuxInInPortout, 32'h22);
    step(0, 0, '0, 1, 0, '0, 0, 0);
    check("t2_empty", DW'(in_empty), 1);
    check("t2_bus0", BusMuxInInPortout, 0);
    step(0, 0, '0, 1, 0, '0, 0, 0);  // pop while empty
    check("t2_pop_empty_bus", BusMuxInInPortout, 0);

    // 3. overfill by one
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 32'hA0 + DW'(i), 0, 0, '0, 0, 0);
      idle();
    end
    check("t3_full", DW'(in_full), 1);
    check("t3_ovr", DW'(in_overrun), 1);
    step(0, 0, '0, 0, 0, '0, 0, 1);
    check("t3_ovr_clr", DW'(in_overrun), 0);

    // 4. push + pop while full
    step(0, 1, 32'hB0, 1, 0, '0, 0, 0);
    idle();
    check("t4_head", BusMuxInInPortout, 32'hA1);
    check("t4_full", DW'(in_full), 1);
    check("t4_ovr", DW'(in_overrun), 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 0, '0, 0, 0);
    check("t4_drained", DW'(in_empty), 1);

    // 5. output side
    step(0, 0, '0, 0, 1, 32'hFFFF, 0, 0);
    step(0, 0, '0, 0, 1, 32'h50, 0, 0);
    check("t5_valid", DW'(out_valid), 1);
    check("t5_head0", output_data, 32'hFFFF);
    step(0, 0, '0, 0, 0, '0, 1, 0);
    check("t5_head1", output_data, 32'h50);
    step(0, 0, '0, 0, 0, '0, 1, 0);
    check("t5_valid0", DW'(out_valid), 0);

    // 6. held strobe, then clear mid-burst
    for (int i = 0; i < 3; i++) step(0, 1, 32'h7, 0, 0, '0, 0, 0);
    idle();
    check("t6_head", BusMuxInInPortout, 32'h7);
    step(0, 0, '0, 1, 0, '0, 0, 0);
`ifdef STROBE_EDGE_EN
    check("t6_after_pop", DW'(in_empty), 1);
`else
    check("t6_after_pop", BusMuxInInPortout, 32'h7);
`endif
    step(0, 1, 32'h1234, 0, 1, 32'h99, 0, 0);
    step(1, 1, 32'h5678, 0, 1, 32'h98, 0, 0);
    check("t6_clr_in_empty", DW'(in_empty), 1);
    check("t6_clr_out_empty", DW'(out_empty), 1);
    idle();

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      step(($urandom_range(63) == 0),
           ($urandom_range(2) != 0), $urandom,
           ($urandom_range(2) == 0),
           ($urandom_range(2) != 0), $urandom,
           ($urandom_range(2) == 0),
           ($urandom_range(15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
